// File: rtl/uart_mon_cmd_if.sv
// Memory access port of the monitor command engine: one request at a time,
// re/we held until a single-cycle ack.
interface uart_mon_cmd_if;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [31:0] rdata;
  logic        ack;

  modport master (output adr, wdata, re, we, input rdata, ack);
  modport slave  (input adr, wdata, re, we, output rdata, ack);
endinterface

// File: rtl/uart_mon_cmd.sv
// Monitor command engine: pops bytes from the rx FIFO, echoes them, parses
// "r <adr>" / "w <adr> <dat>" lines, performs one memory access per line and
// writes the reply into the tx FIFO.
module uart_mon_cmd (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_rdata,
  input  logic             rx_fifo_dvalid,
  output logic             rx_rden,
  output logic [7:0]       tx_wdata,
  output logic             tx_wten,
  input  logic             tx_fifo_full,
  output logic             mon_busy,
  uart_mon_cmd_if.master   mon
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_RESP} state_t;

  state_t      state, state_nx;

  logic        rden_prev;
  logic        cmd_set;
  logic        cmd_w;
  logic [1:0]  field;
  logic [3:0]  adr_cnt;
  logic [3:0]  dat_cnt;
  logic        err;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [31:0] rdata_q;
  // Reply position: 0-7 hex digits, 8 '?', 9 CR, 10 LF. Each reply kind
  // starts at a different index and shares the CR/LF tail.
  logic [3:0]  resp_idx;

  logic        pop;
  logic        is_cr, is_lf, is_sp, is_cmd, is_hex;
  logic [3:0]  nib;
  logic        go_read, go_write, go_empty;
  logic [31:0] rd_sh;
  logic [7:0]  resp_byte;

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    else            return c[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign pop    = (state == S_IDLE) & rx_fifo_dvalid & ~tx_fifo_full & ~rden_prev & ~rst;
  assign is_cr  = (rx_rdata == 8'h0D);
  assign is_lf  = (rx_rdata == 8'h0A);
  assign is_sp  = (rx_rdata == 8'h20);
  assign is_cmd = (rx_rdata == 8'h72) | (rx_rdata == 8'h52) |
                  (rx_rdata == 8'h77) | (rx_rdata == 8'h57);
  assign is_hex = ((rx_rdata >= 8'h30) && (rx_rdata <= 8'h39)) ||
                  ((rx_rdata >= 8'h41) && (rx_rdata <= 8'h46)) ||
                  ((rx_rdata >= 8'h61) && (rx_rdata <= 8'h66));
  assign nib    = hex_val(rx_rdata);

  assign go_read  = cmd_set & ~cmd_w & (adr_cnt != 4'd0) & (dat_cnt == 4'd0) & ~err;
  assign go_write = cmd_set &  cmd_w & (adr_cnt != 4'd0) & (dat_cnt != 4'd0) & ~err;
  assign go_empty = ~cmd_set & ~err;

  assign rd_sh = rdata_q << {resp_idx[2:0], 2'b00};

  // Reply byte for the current index
  always_comb begin
    resp_byte = 8'h0A;
    if (resp_idx < 4'd8)       resp_byte = hex_chr(rd_sh[31:28]);
    else if (resp_idx == 4'd8) resp_byte = 8'h3F;
    else if (resp_idx == 4'd9) resp_byte = 8'h0D;
  end

  assign mon.adr   = adr;
  assign mon.wdata = dat;
  assign mon_busy  = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and FIFO / memory strobes
  always_comb begin
    state_nx = state;
    rx_rden  = 1'b0;
    tx_wten  = 1'b0;
    tx_wdata = '0;
    mon.re   = 1'b0;
    mon.we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          rx_rden = 1'b1;
          if (is_cr) begin
            state_nx = S_EXEC;
          end else if (!is_lf) begin
            tx_wten  = 1'b1;
            tx_wdata = rx_rdata;
          end
        end
      end
      S_EXEC: state_nx = (go_read | go_write) ? S_MEM : S_RESP;
      S_MEM: begin
        mon.re = ~cmd_w;
        mon.we = cmd_w;
        if (mon.ack) state_nx = S_RESP;
      end
      S_RESP: begin
        if (!tx_fifo_full) begin
          tx_wten  = 1'b1;
          tx_wdata = resp_byte;
          if (resp_idx == 4'd10) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Line parser, read-data capture and reply sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      rden_prev <= 1'b0;
      cmd_set   <= 1'b0;
      cmd_w     <= 1'b0;
      field     <= '0;
      adr_cnt   <= '0;
      dat_cnt   <= '0;
      err       <= 1'b0;
      adr       <= '0;
      dat       <= '0;
      rdata_q   <= '0;
      resp_idx  <= '0;
    end else begin
      rden_prev <= rx_rden;
      case (state)
        S_IDLE: begin
          if (pop && !is_cr && !is_lf) begin
            if (is_cmd) begin
              if (!cmd_set) begin
                cmd_set <= 1'b1;
                cmd_w   <= rx_rdata[2];
              end else begin
                err <= 1'b1;
              end
            end else if (is_sp) begin
              if (cmd_set) begin
                if (field == 2'd0)                           field <= 2'd1;
                else if ((field == 2'd1) && (adr_cnt != 4'd0)) field <= 2'd2;
              end
            end else if (is_hex) begin
              if (field == 2'd1) begin
                adr     <= {adr[27:0], nib};
                adr_cnt <= (adr_cnt == 4'd8) ? 4'd8 : adr_cnt + 4'd1;
              end else if (field == 2'd2) begin
                dat     <= {dat[27:0], nib};
                dat_cnt <= (dat_cnt == 4'd8) ? 4'd8 : dat_cnt + 4'd1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (go_read)                  resp_idx <= 4'd0;
          else if (go_write || go_empty) resp_idx <= 4'd9;
          else                          resp_idx <= 4'd8;
        end
        S_MEM: begin
          if (mon.ack && !cmd_w) rdata_q <= mon.rdata;
        end
        S_RESP: begin
          if (!tx_fifo_full) begin
            if (resp_idx == 4'd10) begin
              cmd_set <= 1'b0;
              cmd_w   <= 1'b0;
              field   <= '0;
              adr_cnt <= '0;
              dat_cnt <= '0;
              err     <= 1'b0;
              adr     <= '0;
              dat     <= '0;
            end else begin
              resp_idx <= (resp_idx == 4'd7) ? 4'd9 : resp_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mon_cmd.sv
// Directed bench for uart_mon_cmd: rx FIFO model, memory responder with
// programmable ack delay, tx byte capture and protocol-rule counters.
module tb_uart_mon_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_rdata;
  logic       rx_fifo_dvalid;
  logic       rx_rden;
  logic [7:0] tx_wdata;
  logic       tx_wten;
  logic       tx_fifo_full;
  logic       mon_busy;

  uart_mon_cmd_if mon_if();

  uart_mon_cmd dut (
    .clk            (clk),
    .rst            (rst),
    .rx_rdata       (rx_rdata),
    .rx_fifo_dvalid (rx_fifo_dvalid),
    .rx_rden        (rx_rden),
    .tx_wdata       (tx_wdata),
    .tx_wten        (tx_wten),
    .tx_fifo_full   (tx_fifo_full),
    .mon_busy       (mon_busy),
    .mon            (mon_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // rx FIFO model: pop observed mid-cycle, applied just after the edge
  logic [7:0] rxq[$];
  logic       pop_seen;
  always @(negedge clk) pop_seen = rx_rden;
  always @(posedge clk) begin
    #1;
    if (pop_seen && rxq.size() != 0) void'(rxq.pop_front());
    rx_fifo_dvalid = (rxq.size() != 0);
    rx_rdata       = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // Memory responder, tx capture and rule monitors
  logic [7:0]  txq[$];
  int          ack_delay = 1;
  int          req_cyc = 0;
  int          n_re = 0, n_we = 0, viol = 0;
  logic [31:0] last_adr = '0, last_wdata = '0;
  logic        re_q = 1'b0, we_q = 1'b0, rden_q = 1'b0;
  always @(negedge clk) begin
    if (tx_wten === 1'b1) begin
      txq.push_back(tx_wdata);
      if (tx_fifo_full) viol++;
    end
    if (rx_rden === 1'b1 && (!rx_fifo_dvalid || rden_q)) viol++;
    rden_q = (rx_rden === 1'b1);
    if (mon_if.re === 1'b1 && !re_q) begin n_re++; last_adr = mon_if.adr; end
    if (mon_if.we === 1'b1 && !we_q) begin
      n_we++; last_adr = mon_if.adr; last_wdata = mon_if.wdata;
    end
    re_q = (mon_if.re === 1'b1);
    we_q = (mon_if.we === 1'b1);
    if (re_q || we_q) req_cyc++; else req_cyc = 0;
    mon_if.ack = (re_q || we_q) && (req_cyc == ack_delay);
  end

  function automatic logic [255:0] pack_tx();
    logic [255:0] v = '0;
    foreach (txq[i]) v = {v[247:0], txq[i]};
    return v;
  endfunction

  function automatic logic [255:0] pack_str(input string s);
    logic [255:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[247:0], s[i]};
    return v;
  endfunction

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    int idle = 0;
    bit done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (rxq.size() == 0 && !mon_busy) idle++; else idle = 0;
      if (idle >= 4) done = 1;
    end
    check({tag, "_timeout"}, done, 1);
  endtask

  task automatic expect_tx(input string tag, input string s);
    check({tag, "_len"}, txq.size(), s.len());
    check(tag, pack_tx(), pack_str(s));
  endtask

  task automatic run(input string tag, input string line, input string exp);
    txq.delete();
    send(line);
    wait_idle(tag);
    expect_tx({tag, "_tx"}, exp);
  endtask

  task automatic wait_req(input string tag);
    bit seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (mon_if.re === 1'b1 || mon_if.we === 1'b1) seen = 1;
    end
    check({tag, "_req_seen"}, seen, 1);
  endtask

  int b_re, b_we;

  initial begin
    rst = 1'b1;
    tx_fifo_full = 1'b0;
    mon_if.rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_rden", rx_rden, 0);
    check("rst_tx_wten", tx_wten, 0);
    check("rst_mon_re", mon_if.re, 0);
    check("rst_mon_we", mon_if.we, 0);
    check("rst_mon_adr", mon_if.adr, 0);
    check("rst_busy", mon_busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read with ack three cycles into the request
    b_re = n_re; b_we = n_we;
    ack_delay = 3; mon_if.rdata = 32'hDEADBEEF;
    run("rd", "r 1000\r", "r 1000DEADBEEF\r\n");
    check("rd_n_re", n_re - b_re, 1);
    check("rd_n_we", n_we - b_we, 0);
    check("rd_adr", last_adr, 32'h0000_1000);

    // Write, ack in first request cycle
    b_re = n_re; b_we = n_we;
    ack_delay = 1;
    run("wr", "W 20 a5\r", "W 20 a5\r\n");
    check("wr_n_we", n_we - b_we, 1);
    check("wr_n_re", n_re - b_re, 0);
    check("wr_adr", last_adr, 32'h0000_0020);
    check("wr_wdata", last_wdata, 32'h0000_00A5);

    // Error and empty lines: no memory traffic
    b_re = n_re; b_we = n_we;
    run("bad", "x\r", "x?\r\n");
    run("empty", "\r", "\r\n");
    run("rnoadr", "r\r", "r?\r\n");
    run("wnodat", "w 5\r", "w 5?\r\n");
    check("err_no_access", (n_re - b_re) + (n_we - b_we), 0);

    // Overlong address keeps the last eight digits
    b_re = n_re;
    mon_if.rdata = 32'h0123ABCD;
    run("long", "r 123456789\r", "r 1234567890123ABCD\r\n");
    check("long_adr", last_adr, 32'h2345_6789);
    check("long_n_re", n_re - b_re, 1);

    // Collapsed spaces, LF ignored and not echoed
    mon_if.rdata = 32'h0000_0007;
    run("sp", "r  10\n\r", "r  1000000007\r\n");
    check("sp_adr", last_adr, 32'h0000_0010);

    // Back-pressure across a read reply; a queued CR must stay in the rx FIFO
    txq.delete();
    b_re = n_re;
    ack_delay = 2; mon_if.rdata = 32'h12345678;
    send("r 4\r");
    wait_req("bp");
    @(posedge clk); #1;
    tx_fifo_full = 1'b1;
    rxq.push_back(8'h0D);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_rx_held", rxq.size(), 1);
    check("bp_tx_held", txq.size(), 3);
    check("bp_busy", mon_busy, 1);
    @(posedge clk); #1;
    tx_fifo_full = 1'b0;
    wait_idle("bp");
    expect_tx("bp_tx", "r 412345678\r\n\r\n");
    check("bp_n_re", n_re - b_re, 1);

    // Reset while the read request is outstanding
    txq.delete();
    ack_delay = 1000;
    send("r 8\r");
    wait_req("mrst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_re", mon_if.re, 0);
    check("mrst_busy", mon_busy, 0);
    rst = 1'b0;
    ack_delay = 1;
    repeat (2) @(negedge clk);
    b_re = n_re;
    mon_if.rdata = 32'hCAFE0001;
    run("post", "r 4\r", "r 4CAFE0001\r\n");
    check("post_adr", last_adr, 32'h0000_0004);
    check("post_n_re", n_re - b_re, 1);

    check("rule_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
